// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
  localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog wait counter; expired_c is high during the TIMEOUT-th enabled cycle.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  assign expired_c = (cnt == CNT_W'(TIMEOUT - 1));

  // Saturates at the expiry value so a stuck enable never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory with a hung-memory watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err,
  output logic [ADDR_W-1:0]   err_addr
);

  state_e            state;
  owner_e            owner;
  owner_e            grant_c;
  logic              any_req_c;
  logic              tmr_clr_c;
  logic              tmr_en_c;
  logic              tmr_expired_c;
  logic [DATA_W-1:0] rsp_data_c;

  assign any_req_c = if_req | dm_req;
  assign tmr_en_c  = (state == BUSY);
  assign tmr_clr_c = (state != BUSY);

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (tmr_clr_c),
    .en        (tmr_en_c),
    .expired_c (tmr_expired_c)
  );

`ifdef MEM_ARB_RR_EN
  owner_e last_owner;

  // On contention the port that did not win last time gets the memory.
  always_comb begin
    grant_c = OWN_IF;
    if (if_req && dm_req) begin
      grant_c = (last_owner == OWN_DM) ? OWN_IF : OWN_DM;
    end else if (dm_req) begin
      grant_c = OWN_DM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= OWN_DM;
    end else if (state == IDLE && any_req_c) begin
      last_owner <= grant_c;
    end
  end
`else
  always_comb begin
    grant_c = dm_req ? OWN_DM : OWN_IF;
  end
`endif

  // Stores return zero; a watchdog abort returns the poison word.
  always_comb begin
    rsp_data_c = DATA_W'(ERR_DATA);
    if (mem_ack) begin
      rsp_data_c = mem_we ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_ack    <= 1'b0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            owner   <= grant_c;
            mem_req <= 1'b1;
            state   <= BUSY;
            if (grant_c == OWN_DM) begin
              mem_we    <= dm_we;
              mem_be    <= dm_be;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_be    <= '1;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        BUSY: begin
          // A mem_ack in the expiry cycle still counts as a normal completion.
          if (mem_ack || tmr_expired_c) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (owner == OWN_DM) begin
              dm_ack   <= 1'b1;
              dm_rdata <= rsp_data_c;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= rsp_data_c;
            end
            if (!mem_ack) begin
              err <= 1'b1;
              if (!err) begin
                err_addr <= mem_addr;
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized scoreboard run.
module tb_mem_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;
  logic [31:0] err_addr;

  int checks   = 0;
  int failures = 0;

  bit resp_en    = 1'b0;
  int resp_max   = 0;
  int resp_fixed = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_be     (dm_be),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err),
    .err_addr  (err_addr)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Expected winner: 1 = data, 0 = fetch.
  function automatic int pick(input bit ip, input bit dp, input int last);
`ifdef MEM_ARB_RR_EN
    if (ip && dp) return (last == 1) ? 0 : 1;
`endif
    return dp ? 1 : 0;
  endfunction

  // Memory model: acknowledges after a chosen delay, returns stored words.
  initial begin : responder
    int wcnt;
    int dly;
    logic [31:0] w;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wcnt      = 0;
    dly       = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wcnt      = 0;
      end else if (mem_req && resp_en) begin
        if (wcnt == 0) dly = (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(resp_max, 0));
        if (wcnt == dly) begin
          w = mem_model.exists(mem_addr) ? mem_model[mem_addr] : init_word(mem_addr);
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_model[mem_addr] = merge(w, mem_wdata, mem_be);
            mem_rdata = $urandom;
          end else begin
            mem_rdata = w;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (mem_req !== 1'b0 || if_ack !== 1'b0 || dm_ack !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got req=%b if_ack=%b dm_ack=%b err=%b want all 0",
               mem_req, if_ack, dm_ack, err);
    end
    checks++;
    if (mem_addr !== 32'h0 || err_addr !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0 ||
        mem_we !== 1'b0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h err_addr=%h if_rd=%h dm_rd=%h want all 0",
               mem_addr, err_addr, if_rdata, dm_rdata);
    end
  endtask

  task automatic test_fetch();
    resp_en = 1'b1;
    resp_fixed = 0;
    mem_model[32'h40] = 32'h2402000A;
    if_addr = 32'h40;
    if_req  = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL fetch_cmd got req=%b addr=%h we=%b want 1/00000040/0", mem_req, mem_addr, mem_we);
    end
    tick();
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h2402000A || dm_ack !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ack got if_ack=%b rdata=%h dm_ack=%b want 1/2402000a/0", if_ack, if_rdata, dm_ack);
    end
    if_req = 1'b0;
    tick();
    checks++;
    if (if_ack !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ack_width got if_ack=%b want 0", if_ack);
    end
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_no_double got mem_req=%b want 0", mem_req);
    end
  endtask

  task automatic test_store();
    int  acks;
    bit  seen;
    resp_fixed = 1;
    acks = 0;
    seen = 1'b0;
    dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h100; dm_wdata = 32'h1234;
    dm_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (mem_req && !seen) begin
        seen = 1'b1;
        checks++;
        if (mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 32'h100 || mem_wdata !== 32'h1234) begin
          failures++;
          $display("FAIL store_cmd got we=%b be=%b addr=%h wdata=%h want 1/0011/00000100/00001234",
                   mem_we, mem_be, mem_addr, mem_wdata);
        end
      end
      if (if_ack) acks += 100;
      if (dm_ack) begin
        acks++;
        checks++;
        if (dm_rdata !== 32'h0) begin
          failures++;
          $display("FAIL store_rdata got %h want 0", dm_rdata);
        end
        dm_req = 1'b0;
      end
    end
    checks++;
    if (acks != 1 || !seen) begin
      failures++;
      $display("FAIL store_ack_count got %0d seen_cmd=%0d want 1/1", acks, seen);
    end
  endtask

  // mem_ack in the last allowed cycle wins; dropping req mid-access is harmless.
  task automatic test_ack_boundary();
    int  req_cyc;
    bit  got;
    resp_fixed = int'(TO) - 1;
    req_cyc = 0;
    got = 1'b0;
    dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h180; dm_wdata = 32'h0;
    dm_req = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (mem_req) req_cyc++;
      if (req_cyc == 2) dm_req = 1'b0;
      if (dm_ack) begin
        got = 1'b1;
        checks++;
        if (dm_rdata !== init_word(32'h180) || err !== 1'b0) begin
          failures++;
          $display("FAIL edge_ack got rdata=%h err=%b want %h/0", dm_rdata, err, init_word(32'h180));
        end
      end
    end
    dm_req = 1'b0;
    checks++;
    if (!got || req_cyc != int'(TO)) begin
      failures++;
      $display("FAIL edge_req_cycles got ack=%0d cycles=%0d want 1/%0d", got, req_cyc, TO);
    end
    tick();
  endtask

  task automatic test_arbitration();
    int rounds;
    int last;
    int got;
    int want;
    do_reset();
    resp_fixed = -1;
    resp_max = 2;
    rounds = 0;
    last = 1;
    if_addr = 32'h500;
    dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h600;
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int c = 0; c < 80 && rounds < 3; c++) begin
      tick();
      if (if_ack || dm_ack) begin
        got = dm_ack ? 1 : 0;
        want = pick(1'b1, 1'b1, last);
        last = want;
        checks++;
        if (got != want || (if_ack && dm_ack)) begin
          failures++;
          $display("FAIL arb_order round=%0d got=%0d want=%0d (1=dm)", rounds, got, want);
        end
        checks++;
        if (got == 1 ? (dm_rdata !== init_word(dm_addr)) : (if_rdata !== init_word(if_addr))) begin
          failures++;
          $display("FAIL arb_data round=%0d got if=%h dm=%h", rounds, if_rdata, dm_rdata);
        end
        if (got == 1) dm_addr += 32'd4;
        else if_addr += 32'd4;
        rounds++;
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    checks++;
    if (rounds != 3) begin
      failures++;
      $display("FAIL arb_rounds got %0d want 3", rounds);
    end
    repeat (3) tick();
  endtask

  task automatic test_random();
    int done;
    int exp_own;
    int last;
    int got;
    bit m_busy;
    bit skip;
    logic [31:0] want;
    do_reset();
    resp_en = 1'b1;
    resp_fixed = -1;
    resp_max = 5;
    done = 0; last = 1; m_busy = 1'b0; exp_own = 0;
    for (int c = 0; c < 3000 && done < 40; c++) begin
      skip = 1'b0;
      if (m_busy && mem_req) begin
        checks++;
        if (mem_addr !== (exp_own == 1 ? dm_addr : if_addr) ||
            mem_we !== (exp_own == 1 ? dm_we : 1'b0)) begin
          failures++;
          $display("FAIL rnd_cmd got addr=%h we=%b own=%0d", mem_addr, mem_we, exp_own);
        end
      end
      if (if_ack || dm_ack) begin
        got = dm_ack ? 1 : 0;
        checks++;
        if (!m_busy || got != exp_own || (if_ack && dm_ack)) begin
          failures++;
          $display("FAIL rnd_owner got=%0d want=%0d busy=%0d", got, exp_own, m_busy);
        end
        if (got == 1) begin
          if (dm_we) begin
            want = 32'h0;
            ref_mem[dm_addr] = merge(rd_ref(dm_addr), dm_wdata, dm_be);
          end else begin
            want = rd_ref(dm_addr);
          end
          checks++;
          if (dm_rdata !== want) begin
            failures++;
            $display("FAIL rnd_dm_data addr=%h got=%h want=%h", dm_addr, dm_rdata, want);
          end
          dm_req = 1'b0;
        end else begin
          want = rd_ref(if_addr);
          checks++;
          if (if_rdata !== want) begin
            failures++;
            $display("FAIL rnd_if_data addr=%h got=%h want=%h", if_addr, if_rdata, want);
          end
          if_req = 1'b0;
        end
        m_busy = 1'b0;
        skip = 1'b1;
        done++;
      end
      if (!if_req && $urandom_range(3) == 0) begin
        if_addr = 32'h1000 + 32'($urandom_range(7)) * 4;
        if_req = 1'b1;
      end
      if (!dm_req && $urandom_range(2) == 0) begin
        dm_addr  = 32'h1000 + 32'($urandom_range(7)) * 4;
        dm_we    = 1'($urandom_range(1));
        dm_be    = 4'($urandom_range(15, 1));
        dm_wdata = $urandom;
        dm_req   = 1'b1;
      end
      if (!m_busy && !skip && (if_req || dm_req)) begin
        exp_own = pick(if_req, dm_req, last);
        last = exp_own;
        m_busy = 1'b1;
      end
      tick();
    end
    checks++;
    if (done != 40) begin
      failures++;
      $display("FAIL rnd_progress got %0d want 40", done);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (15) tick();
  endtask

  task automatic test_timeout();
    logic [31:0] addrs [2];
    int req_cyc;
    bit got;
    addrs[0] = 32'h200;
    addrs[1] = 32'h300;
    resp_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_cyc = 0;
      got = 1'b0;
      dm_we = 1'b0; dm_be = 4'hF; dm_addr = addrs[k];
      dm_req = 1'b1;
      for (int c = 0; c < 30 && !got; c++) begin
        tick();
        if (mem_req) req_cyc++;
        if (dm_ack) begin
          got = 1'b1;
          dm_req = 1'b0;
          checks++;
          if (dm_rdata !== 32'hDEAD_BEEF || err !== 1'b1 || err_addr !== 32'h200) begin
            failures++;
            $display("FAIL timeout_%0d got rdata=%h err=%b err_addr=%h want deadbeef/1/00000200",
                     k, dm_rdata, err, err_addr);
          end
        end
      end
      dm_req = 1'b0;
      checks++;
      if (!got || req_cyc != int'(TO)) begin
        failures++;
        $display("FAIL timeout_cycles_%0d got ack=%0d cycles=%0d want 1/%0d", k, got, req_cyc, TO);
      end
      tick();
    end
  endtask

  task automatic test_idle_ack();
    int stray;
    resp_en = 1'b0;
    stray = 0;
    @(negedge clk);
    mem_rdata = 32'h77;
    mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (if_ack || dm_ack || mem_req) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL idle_ack_stray got %0d want 0", stray);
    end
    resp_en = 1'b1;
    resp_fixed = 0;
    if_addr = 32'h44;
    if_req = 1'b1;
    tick();
    tick();
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== init_word(32'h44)) begin
      failures++;
      $display("FAIL idle_ack_after got if_ack=%b rdata=%h want 1/%h", if_ack, if_rdata, init_word(32'h44));
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int stray;
    resp_en = 1'b0;
    stray = 0;
    dm_we = 1'b0; dm_addr = 32'h400;
    dm_req = 1'b1;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rmid_busy got mem_req=%b want 1", mem_req);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rmid_async got mem_req=%b err=%b want 0/0", mem_req, err);
    end
    dm_req = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (if_ack || dm_ack || mem_req || err) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL rmid_after got %0d stray cycles want 0", stray);
    end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_fetch();
    test_store();
    test_ack_boundary();
    test_arbitration();
    test_random();
    test_timeout();
    test_idle_ack();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
